addsub_chunked: RTL

Multi-cycle, parametrised adder/subtractor for wide operands. It processes an N-bit operation K bits per clock through a single K-bit adder slice and keeps the inter-chunk carry in a register. This trades latency for area compared with the flat ripple-carry adders in the arithmetic library. It sits alongside those adders and serves datapaths where operands are wide (34+ bits) and a few cycles of latency are acceptable, with a start/busy/done handshake to the controlling logic.

---
 rtl/addsub_chunked_if.sv | 28 ++
 rtl/addsub_chunked.sv | 121 ++++++++++++
 2 files changed

// File: rtl/addsub_chunked_if.sv
// addsub_chunked_if -- operand/result bundle for the chunked adder/subtractor.
//
// master modport (controller) : drives start, sub, a, b; observes the rest
// slave  modport (datapath)   : receives start, sub, a, b; drives
//                               busy, done, s, c_out, ovf
interface addsub_chunked_if #(
  parameter int N = 34
);
  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         c_out;
  logic         ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, s, c_out, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, s, c_out, ovf
  );
endinterface

// File: rtl/addsub_chunked.sv
// addsub_chunked -- multi-cycle N-bit adder/subtractor using one K-bit slice.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      addsub_chunked_if.slave:
//              start/sub/a/b  request and operands, captured on acceptance
//              busy           high while chunks are processed (M cycles)
//              done           one-cycle pulse when s/c_out/ovf update
//              s, c_out, ovf  result, carry out of bit N-1, signed overflow
//
// An operation takes M = ceil(N/K) edges after the accept edge. The carry
// between chunks lives in a register; results hold until the next completion.
module addsub_chunked #(
  parameter int N = 34,
  parameter int K = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  addsub_chunked_if.slave  bus
);

  localparam int M  = (N + K - 1) / K;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  // Valid bits in the last chunk; carry out of bit N-1 sits at this position.
  localparam int L  = N - (M - 1) * K;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q;      // b_q already holds b' = sub ? ~b : b
  logic [N-1:0]   work_q, work_d;
  logic           carry_q;
  logic [IW-1:0]  idx_q;
  logic [N-1:0]   s_q;
  logic           c_out_q, ovf_q;

  logic [K-1:0]   a_chunk, b_chunk;
  logic [K:0]     chunk_sum;
  logic           accept, last;

  assign accept = bus.start && (state_q != RUN);
  assign last   = (state_q == RUN) && (idx_q == LAST_IDX);

  // Chunk select and write-back. Bits past N-1 read as zero and are never
  // written, so the carry out of bit N-1 emerges cleanly at chunk_sum[L].
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    int pos;
    pos     = 0;
    a_chunk = '0;
    b_chunk = '0;
    work_d  = work_q;
    for (int t = 0; t < K; t++) begin
      pos = int'(idx_q) * K + t;
      if (pos < N) begin
        a_chunk[t] = a_q[pos];
        b_chunk[t] = b_q[pos];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry_q};
    for (int j = 0; j < N; j++) begin
      if (j / K == int'(idx_q)) work_d[j] = chunk_sum[j % K];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub;   // +1 completes the two's complement of b
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        work_q  <= work_d;
        carry_q <= chunk_sum[K];
        idx_q   <= idx_q + 1'b1;
        if (last) begin
          s_q     <= work_d;
          c_out_q <= chunk_sum[L];
          ovf_q   <= (a_q[N-1] == b_q[N-1]) && (work_d[N-1] != a_q[N-1]);
        end
      end
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;

endmodule
